// File: rtl/soc_obi_arbiter_if.sv
// Bus bundle for soc_obi_arbiter. The slave modport faces the N requesters.
// The master modport faces the single downstream OBI slave.
interface soc_obi_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32
);
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  // Requester side
  logic [NUM_MASTERS-1:0]                 m_req_i;
  logic [NUM_MASTERS-1:0]                 m_we_i;
  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] m_addr_i;
  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] m_wdata_i;
  logic [NUM_MASTERS-1:0][BE_WIDTH-1:0]   m_be_i;
  logic [NUM_MASTERS-1:0]                 m_gnt_o;
  logic [NUM_MASTERS-1:0]                 m_rvalid_o;
  logic [DATA_WIDTH-1:0]                  m_rdata_o;

  // Downstream side
  logic                  s_req_o;
  logic                  s_we_o;
  logic [ADDR_WIDTH-1:0] s_addr_o;
  logic [DATA_WIDTH-1:0] s_wdata_o;
  logic [BE_WIDTH-1:0]   s_be_o;
  logic                  s_gnt_i;
  logic                  s_rvalid_i;
  logic [DATA_WIDTH-1:0] s_rdata_i;

  modport slave (
    input  m_req_i, m_we_i, m_addr_i, m_wdata_i, m_be_i,
    output m_gnt_o, m_rvalid_o, m_rdata_o
  );

  modport master (
    output s_req_o, s_we_o, s_addr_o, s_wdata_o, s_be_o,
    input  s_gnt_i, s_rvalid_i, s_rdata_i
  );
endinterface

// File: rtl/soc_obi_arbiter.sv
// Round-robin N:1 OBI arbiter with in-order response routing FIFO.
// Optional per-master grant counters are enabled by defining SOC_OBI_ARB_PERF_EN.
module soc_obi_arbiter #(
  parameter int unsigned NUM_MASTERS     = 2,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  soc_obi_arbiter_if.slave                m_bus,
  soc_obi_arbiter_if.master               s_bus,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding_o,
  output logic                            resp_err_o
`ifdef SOC_OBI_ARB_PERF_EN
  ,
  output logic [NUM_MASTERS-1:0][31:0]    perf_gnt_cnt_o
`endif
);

  localparam int unsigned IDX_W    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned PTR_W    = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e                                state_q, state_d;
  logic [IDX_W-1:0]                      sel_q, sel_d;
  logic [IDX_W-1:0]                      rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]                      wptr_q, wptr_d;
  logic [PTR_W-1:0]                      rptr_q, rptr_d;
  logic [CNT_W-1:0]                      count_q, count_d;
  logic [MAX_OUTSTANDING-1:0][IDX_W-1:0] fifo_q, fifo_d;
  logic                                  resp_err_q, resp_err_d;

  logic [IDX_W-1:0]       rr_sel;
  logic [IDX_W-1:0]       cand;
  logic [IDX_W-1:0]       sel;
  logic [IDX_W-1:0]       head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   s_req;
  logic                   hs;
  logic                   pop;
  logic [NUM_MASTERS-1:0] gnt;
  logic [NUM_MASTERS-1:0] rvalid;

  // First requester at or after rr_ptr; descending scan so offset 0 wins last.
  always_comb begin : rr_search
    rr_sel = rr_ptr_q;
    cand   = '0;
    for (int i = int'(NUM_MASTERS) - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(rr_ptr_q) + i) % int'(NUM_MASTERS));
      if (m_bus.m_req_i[cand]) begin
        rr_sel = cand;
      end
    end
  end

  // Selection, handshake and response routing
  always_comb begin : route
    sel        = (state_q == HOLD) ? sel_q : rr_sel;
    fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
    fifo_empty = (count_q == '0);
    head       = fifo_q[rptr_q];
    s_req      = m_bus.m_req_i[sel] & ~fifo_full & ~reset_i;
    hs         = s_req & s_bus.s_gnt_i;
    pop        = s_bus.s_rvalid_i & ~fifo_empty & ~reset_i;
    gnt        = '0;
    rvalid     = '0;
    if (hs) begin
      gnt[sel] = 1'b1;
    end
    if (pop) begin
      rvalid[head] = 1'b1;
    end
  end

  // A stalled request keeps its master locked until the slave grants it
  always_comb begin : fsm_next
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (s_req && !s_bus.s_gnt_i) begin
          state_d = HOLD;
          sel_d   = sel;
        end
      end
      HOLD: begin
        if (s_bus.s_gnt_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Routing FIFO and round-robin pointer update
  always_comb begin : fifo_next
    fifo_d     = fifo_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    rr_ptr_d   = rr_ptr_q;
    count_d    = count_q;
    resp_err_d = resp_err_q | (s_bus.s_rvalid_i & fifo_empty);
    if (hs) begin
      fifo_d[wptr_q] = sel;
      wptr_d         = wptr_q + PTR_W'(1);
      rr_ptr_d       = (sel == IDX_W'(NUM_MASTERS - 1)) ? '0 : sel + IDX_W'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PTR_W'(1);
    end
    case ({hs, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      rr_ptr_q   <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      fifo_q     <= '0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      rr_ptr_q   <= rr_ptr_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      fifo_q     <= fifo_d;
      resp_err_q <= resp_err_d;
    end
  end

  // Outputs are forced quiet while reset is asserted
  assign s_bus.s_req_o    = s_req;
  assign s_bus.s_we_o     = m_bus.m_we_i[sel] & ~reset_i;
  assign s_bus.s_addr_o   = reset_i ? {ADDR_WIDTH{1'b0}} : m_bus.m_addr_i[sel];
  assign s_bus.s_wdata_o  = reset_i ? {DATA_WIDTH{1'b0}} : m_bus.m_wdata_i[sel];
  assign s_bus.s_be_o     = reset_i ? {BE_WIDTH{1'b0}} : m_bus.m_be_i[sel];
  assign m_bus.m_gnt_o    = gnt;
  assign m_bus.m_rvalid_o = rvalid;
  assign m_bus.m_rdata_o  = reset_i ? {DATA_WIDTH{1'b0}} : s_bus.s_rdata_i;
  assign outstanding_o    = count_q;
  assign resp_err_o       = resp_err_q;

`ifdef SOC_OBI_ARB_PERF_EN
  logic [NUM_MASTERS-1:0][31:0] perf_q, perf_d;

  // Saturating per-master handshake counters
  always_comb begin : perf_next
    perf_d = perf_q;
    if (hs && (perf_q[sel] != 32'hFFFF_FFFF)) begin
      perf_d[sel] = perf_q[sel] + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_gnt_cnt_o = perf_q;
`endif

endmodule

// File: tb/tb_soc_obi_arbiter.sv
// Self-checking bench for soc_obi_arbiter: directed vector table, hand-written
// corner sequences, and randomized traffic against a queue-based reference model.
module tb_soc_obi_arbiter;
  localparam int unsigned NM = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;
  localparam int unsigned MO = 4;
  localparam int unsigned CW = $clog2(MO) + 1;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic [CW-1:0] outstanding_o;
  logic          resp_err_o;
`ifdef SOC_OBI_ARB_PERF_EN
  logic [NM-1:0][31:0] perf_gnt_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  soc_obi_arbiter_if #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  soc_obi_arbiter #(
    .NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .m_bus         (bus),
    .s_bus         (bus),
    .outstanding_o (outstanding_o),
    .resp_err_o    (resp_err_o)
`ifdef SOC_OBI_ARB_PERF_EN
    ,
    .perf_gnt_cnt_o(perf_gnt_cnt_o)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: arbitration in terms of the rules, routing as a queue
  int          m_rr;
  int          m_hold;
  int          m_q[$];
  bit          m_err;
  bit [31:0]   m_perf[NM];

  function automatic void model_reset();
    m_rr   = 0;
    m_hold = -1;
    m_q.delete();
    m_err  = 1'b0;
    for (int k = 0; k < NM; k++) m_perf[k] = 32'd0;
  endfunction

  function automatic int model_sel(input logic [NM-1:0] req);
    int j;
    if (m_hold >= 0) return m_hold;
    for (int k = 0; k < NM; k++) begin
      j = (m_rr + k) % NM;
      if (req[j]) return j;
    end
    return m_rr;
  endfunction

  task automatic set_payload(input bit rnd);
    for (int k = 0; k < NM; k++) begin
      bus.m_addr_i[k]  = rnd ? AW'($urandom()) : AW'(32'h1000 * (k + 1));
      bus.m_wdata_i[k] = rnd ? DW'($urandom()) : DW'(32'hD000 + k);
      bus.m_be_i[k]    = rnd ? BW'($urandom()) : BW'(4'hF);
      bus.m_we_i[k]    = rnd ? 1'($urandom()) : 1'(k);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 time unit later
  task automatic drive(input logic [NM-1:0] req, input logic g, input logic rv,
                       input logic [DW-1:0] rd, input bit rnd);
    @(negedge clk_i);
    bus.m_req_i    = req;
    bus.s_gnt_i    = g;
    bus.s_rvalid_i = rv;
    bus.s_rdata_i  = rd;
    set_payload(rnd);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    reset_i = 1'b1;
    bus.m_req_i = '0; bus.s_gnt_i = 1'b0; bus.s_rvalid_i = 1'b0; bus.s_rdata_i = '0;
    @(negedge clk_i);
    reset_i = 1'b0;
    model_reset();
  endtask

  task automatic model_check(input logic [NM-1:0] req, input logic g, input logic rv,
                             input logic [DW-1:0] rd);
    int            sel;
    bit            sreq;
    logic [NM-1:0] eg, er;
    sel  = model_sel(req);
    sreq = req[sel] && (m_q.size() < MO);
    eg = '0;
    er = '0;
    if (sreq && g) eg[sel] = 1'b1;
    if (rv && m_q.size() > 0) er[m_q[0]] = 1'b1;
    chk("rnd s_req_o", 64'(bus.s_req_o), 64'(sreq));
    chk("rnd m_gnt_o", 64'(bus.m_gnt_o), 64'(eg));
    chk("rnd m_rvalid_o", 64'(bus.m_rvalid_o), 64'(er));
    chk("rnd m_rdata_o", 64'(bus.m_rdata_o), 64'(rd));
    chk("rnd outstanding_o", 64'(outstanding_o), 64'(m_q.size()));
    chk("rnd resp_err_o", 64'(resp_err_o), 64'(m_err));
    if (sreq) begin
      chk("rnd s_addr_o", 64'(bus.s_addr_o), 64'(bus.m_addr_i[sel]));
      chk("rnd s_wdata_o", 64'(bus.s_wdata_o), 64'(bus.m_wdata_i[sel]));
      chk("rnd s_be_o", 64'(bus.s_be_o), 64'(bus.m_be_i[sel]));
      chk("rnd s_we_o", 64'(bus.s_we_o), 64'(bus.m_we_i[sel]));
    end
`ifdef SOC_OBI_ARB_PERF_EN
    for (int k = 0; k < NM; k++) chk("rnd perf_gnt_cnt_o", 64'(perf_gnt_cnt_o[k]), 64'(m_perf[k]));
`endif
    if (rv) begin
      if (m_q.size() > 0) void'(m_q.pop_front());
      else m_err = 1'b1;
    end
    if (sreq && g) begin
      m_q.push_back(sel);
      m_rr = (sel + 1) % NM;
      if (m_perf[sel] != 32'hFFFF_FFFF) m_perf[sel] = m_perf[sel] + 32'd1;
    end
    if (g) m_hold = -1;
    else if (m_hold < 0 && sreq) m_hold = sel;
  endtask

  typedef struct {
    logic [NM-1:0] req;
    logic          gnt;
    logic          rv;
    logic          sreq;
    logic [NM-1:0] mgnt;
    logic [NM-1:0] mrv;
    int            outs;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic [NM-1:0] req, input logic g, input logic rv,
                              input logic sreq, input logic [NM-1:0] mgnt,
                              input logic [NM-1:0] mrv, input int outs);
    vec_t v;
    v.req = req; v.gnt = g; v.rv = rv; v.sreq = sreq; v.mgnt = mgnt; v.mrv = mrv; v.outs = outs;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [NM-1:0] r;
    logic          g, rv;
    logic [DW-1:0] rd;

    // Alternating grants until the FIFO fills, then drain in order
    vecs[0]  = mk(2'b11, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 0);
    vecs[1]  = mk(2'b11, 1'b1, 1'b0, 1'b1, 2'b10, 2'b00, 1);
    vecs[2]  = mk(2'b11, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 2);
    vecs[3]  = mk(2'b11, 1'b1, 1'b0, 1'b1, 2'b10, 2'b00, 3);
    vecs[4]  = mk(2'b11, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 4);
    vecs[5]  = mk(2'b11, 1'b1, 1'b1, 1'b0, 2'b00, 2'b01, 4);
    vecs[6]  = mk(2'b11, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 3);
    vecs[7]  = mk(2'b11, 1'b0, 1'b1, 1'b0, 2'b00, 2'b10, 4);
    vecs[8]  = mk(2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 3);
    vecs[9]  = mk(2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b10, 2);
    vecs[10] = mk(2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 1);
    vecs[11] = mk(2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 0);

    // Outputs stay quiet while reset is held, even with active inputs
    reset_i = 1'b1;
    bus.m_req_i = 2'b11; bus.s_gnt_i = 1'b1; bus.s_rvalid_i = 1'b1; bus.s_rdata_i = 32'h1234;
    set_payload(1'b0);
    #3;
    chk("rst s_req_o", 64'(bus.s_req_o), 64'(0));
    chk("rst m_gnt_o", 64'(bus.m_gnt_o), 64'(0));
    chk("rst m_rvalid_o", 64'(bus.m_rvalid_o), 64'(0));
    chk("rst outstanding_o", 64'(outstanding_o), 64'(0));
    chk("rst resp_err_o", 64'(resp_err_o), 64'(0));
    do_reset();

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].req, vecs[i].gnt, vecs[i].rv, DW'(32'hA0 + i), 1'b0);
      chk($sformatf("vec%0d s_req_o", i), 64'(bus.s_req_o), 64'(vecs[i].sreq));
      chk($sformatf("vec%0d m_gnt_o", i), 64'(bus.m_gnt_o), 64'(vecs[i].mgnt));
      chk($sformatf("vec%0d m_rvalid_o", i), 64'(bus.m_rvalid_o), 64'(vecs[i].mrv));
      chk($sformatf("vec%0d outstanding_o", i), 64'(outstanding_o), 64'(vecs[i].outs));
      chk($sformatf("vec%0d m_rdata_o", i), 64'(bus.m_rdata_o), 64'(32'hA0 + i));
    end

    // Stalled M1 keeps the bus while M0 starts requesting
    do_reset();
    drive(2'b10, 1'b0, 1'b0, '0, 1'b0);
    chk("hold c0 s_addr_o", 64'(bus.s_addr_o), 64'(32'h2000));
    for (int c = 1; c < 3; c++) begin
      drive(2'b11, 1'b0, 1'b0, '0, 1'b0);
      chk($sformatf("hold c%0d s_addr_o", c), 64'(bus.s_addr_o), 64'(32'h2000));
      chk($sformatf("hold c%0d m_gnt_o", c), 64'(bus.m_gnt_o), 64'(0));
    end
    drive(2'b11, 1'b1, 1'b0, '0, 1'b0);
    chk("hold c3 m_gnt_o", 64'(bus.m_gnt_o), 64'(2'b10));
    chk("hold c3 s_we_o", 64'(bus.s_we_o), 64'(1));
    drive(2'b01, 1'b1, 1'b0, '0, 1'b0);
    chk("hold c4 m_gnt_o", 64'(bus.m_gnt_o), 64'(2'b01));
    chk("hold c4 s_addr_o", 64'(bus.s_addr_o), 64'(32'h1000));

    // In-order response routing with data
    do_reset();
    drive(2'b11, 1'b1, 1'b0, '0, 1'b0);
    chk("route g0", 64'(bus.m_gnt_o), 64'(2'b01));
    drive(2'b11, 1'b1, 1'b0, '0, 1'b0);
    chk("route g1", 64'(bus.m_gnt_o), 64'(2'b10));
    drive(2'b11, 1'b1, 1'b0, '0, 1'b0);
    chk("route g2", 64'(bus.m_gnt_o), 64'(2'b01));
    drive(2'b00, 1'b0, 1'b1, 32'hA, 1'b0);
    chk("route r0 rvalid", 64'(bus.m_rvalid_o), 64'(2'b01));
    chk("route r0 rdata", 64'(bus.m_rdata_o), 64'(32'hA));
    drive(2'b00, 1'b0, 1'b1, 32'hB, 1'b0);
    chk("route r1 rvalid", 64'(bus.m_rvalid_o), 64'(2'b10));
    chk("route r1 rdata", 64'(bus.m_rdata_o), 64'(32'hB));
    drive(2'b00, 1'b0, 1'b1, 32'hC, 1'b0);
    chk("route r2 rvalid", 64'(bus.m_rvalid_o), 64'(2'b01));
    chk("route r2 rdata", 64'(bus.m_rdata_o), 64'(32'hC));

    // Unexpected response is flagged and sticky
    drive(2'b00, 1'b0, 1'b1, 32'hE, 1'b0);
    chk("err rvalid", 64'(bus.m_rvalid_o), 64'(0));
    chk("err before edge", 64'(resp_err_o), 64'(0));
    drive(2'b00, 1'b0, 1'b0, '0, 1'b0);
    chk("err set", 64'(resp_err_o), 64'(1));
    drive(2'b11, 1'b1, 1'b0, '0, 1'b0);
    drive(2'b11, 1'b1, 1'b0, '0, 1'b0);
    chk("err sticky", 64'(resp_err_o), 64'(1));
    chk("burst outstanding", 64'(outstanding_o), 64'(1));

    // Reset mid-burst clears everything immediately
    @(negedge clk_i);
    bus.s_rvalid_i = 1'b1;
    reset_i = 1'b1;
    #1;
    chk("midrst s_req_o", 64'(bus.s_req_o), 64'(0));
    chk("midrst m_gnt_o", 64'(bus.m_gnt_o), 64'(0));
    chk("midrst m_rvalid_o", 64'(bus.m_rvalid_o), 64'(0));
    chk("midrst outstanding_o", 64'(outstanding_o), 64'(0));
    chk("midrst resp_err_o", 64'(resp_err_o), 64'(0));
    do_reset();

`ifdef SOC_OBI_ARB_PERF_EN
    begin
      logic [NM-1:0] seq[8];
      seq = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01};
      for (int i = 0; i < 8; i++) drive(seq[i], 1'b1, (i > 0), '0, 1'b0);
      drive(2'b00, 1'b0, 1'b1, '0, 1'b0);
      chk("perf m0", 64'(perf_gnt_cnt_o[0]), 64'(5));
      chk("perf m1", 64'(perf_gnt_cnt_o[1]), 64'(3));
      do_reset();
      #1;
      chk("perf m0 cleared", 64'(perf_gnt_cnt_o[0]), 64'(0));
      chk("perf m1 cleared", 64'(perf_gnt_cnt_o[1]), 64'(0));
    end
`endif

    // Randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      r  = NM'($urandom());
      g  = ($urandom_range(0, 2) != 0);
      rv = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
      rd = DW'($urandom());
      drive(r, g, rv, rd, 1'b1);
      model_check(r, g, rv, rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/soc_obi_arbiter.md
SOC_OBI_ARBITER -- requirements
Module: soc_obi_arbiter

Interface
REQ-001 SHALL provide parameter NUM_MASTERS, default 2, number of OBI-style requester ports, legal range 1..8.
REQ-002 SHALL provide parameter ADDR_WIDTH, default 32, address width.
REQ-003 SHALL provide parameter DATA_WIDTH, default 32, data width, multiple of 8.
REQ-004 SHALL provide parameter MAX_OUTSTANDING, default 4, response-routing FIFO depth, power of two, 2..16.
REQ-005 SHALL have port clk_i, input, 1, single clock, all logic rising-edge.
REQ-006 SHALL have port reset_i, input, 1, asynchronous active-high reset.
REQ-007 SHALL have ports m_req_i/m_we_i, input, NUM_MASTERS, per-master request/write-enable.
REQ-008 SHALL have ports m_addr_i, m_wdata_i, m_be_i, input, NUM_MASTERS x ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8, per-master payload.
REQ-009 SHALL have ports m_gnt_o, m_rvalid_o, output, NUM_MASTERS, per-master grant/response-valid.
REQ-010 SHALL have port m_rdata_o, output, DATA_WIDTH, read data broadcast to all masters.
REQ-011 SHALL have ports s_req_o, s_we_o, s_addr_o, s_wdata_o, s_be_o, output, matching widths, slave-side request.
REQ-012 SHALL have ports s_gnt_i, s_rvalid_i, input, 1, and s_rdata_i, input, DATA_WIDTH, slave-side grant/response.
REQ-013 SHALL have port outstanding_o, output, $clog2(MAX_OUTSTANDING)+1, FIFO occupancy.
REQ-014 SHALL have port resp_err_o, output, 1, sticky unexpected-response flag.

Function
REQ-015 SHALL implement states IDLE and HOLD; IDLE->HOLD when s_req_o=1 and s_gnt_i=0; HOLD->IDLE on s_gnt_i=1; IDLE stays IDLE on same-cycle grant.
REQ-016 In IDLE, sel SHALL be the first asserted m_req_i at or after rr_ptr, searching upward with wrap from NUM_MASTERS-1 to 0.
REQ-017 In HOLD, sel SHALL be the registered index, unchanged until grant, regardless of other requests.
REQ-018 s_req_o SHALL equal m_req_i[sel] AND NOT fifo_full; payload outputs SHALL be the sel master's fields combinationally.
REQ-019 m_gnt_o[sel] SHALL equal s_req_o AND s_gnt_i; all other m_gnt_o bits SHALL be 0.
REQ-020 On handshake (s_req_o & s_gnt_i), rr_ptr SHALL become (sel+1) mod NUM_MASTERS and sel SHALL be pushed into the FIFO.
REQ-021 On s_rvalid_i with FIFO non-empty, m_rvalid_o[head] SHALL be 1 in the same cycle, and head SHALL pop.
REQ-022 Push and pop in the same cycle SHALL both occur with occupancy unchanged; push is blocked only when occupancy equals MAX_OUTSTANDING before the edge.
REQ-023 s_rvalid_i with FIFO empty SHALL drive no m_rvalid_o and SHALL set resp_err_o until reset.
REQ-024 Slave SHALL return responses in order, no earlier than one cycle after grant; same-cycle rvalid is out of contract.
REQ-025 FIFO read/write pointers SHALL wrap modulo MAX_OUTSTANDING; outstanding_o SHALL be exact 0..MAX_OUTSTANDING.

Reset
REQ-026 On reset_i=1, asynchronously: state=IDLE, rr_ptr=0, FIFO empty, outstanding_o=0, resp_err_o=0, counters=0.
REQ-027 During reset, s_req_o, m_gnt_o, m_rvalid_o SHALL be 0; in-flight transactions are discarded, not replayed.
REQ-028 Reset release SHALL be synchronised by the integrator; block treats first post-reset edge as normal operation.

Configuration
REQ-029 With macro SOC_OBI_ARB_PERF_EN defined, SHALL add output perf_gnt_cnt_o, NUM_MASTERS x 32, per-master handshake counters, saturating at 0xFFFFFFFF.
REQ-030 Without SOC_OBI_ARB_PERF_EN, port and counters SHALL be absent; all other behaviour identical.

Verification
REQ-031 NUM_MASTERS=2, both req continuously, s_gnt_i=1 always -> grants alternate M0,M1,M0,M1 from reset.
REQ-032 M1 req, s_gnt_i=0 for 3 cycles, M0 raises req cycle 1 -> s_addr_o holds M1 address, M1 granted cycle 3, then M0.
REQ-033 MAX_OUTSTANDING=4, 4 grants no rvalid -> outstanding_o=4, s_req_o=0; one s_rvalid_i -> outstanding_o=3, s_req_o reasserts next cycle.
REQ-034 Grants M0,M1,M0 then 3 rvalids with rdata 0xA,0xB,0xC -> m_rvalid_o pulses M0,M1,M0 with matching data.
REQ-035 s_rvalid_i with outstanding_o=0 -> resp_err_o=1, no m_rvalid_o; asserting reset_i mid-burst -> all outputs 0 immediately.
REQ-036 PERF_EN build, 5 M0 and 3 M1 handshakes -> perf_gnt_cnt_o = {3,5}; cleared by reset.
